// File: rtl/radar_pkg.sv
// radar_pkg: shared state encodings, field widths and clock-rate default for the radar pulse blocks
package radar_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ON    = 2'd1,
        S_OFF   = 2'd2,
        S_GUARD = 2'd3
    } state_t;

    localparam int CLK_PER_US_DEF = 50;
    localparam int T_W            = 11;
    localparam int Z_W            = 7;
    localparam int PCNT_W         = 16;

endpackage

// File: rtl/us_tick_gen.sv
// us_tick_gen: 1 us tick prescaler counting 0..CLK_PER_US-1
//   clk, reset_n : clock, async active-low reset
//   clr          : synchronous clear, restarts the microsecond
//   tick         : high on the last clk cycle of each microsecond
module us_tick_gen
    import radar_pkg::*;
#(
    parameter int CLK_PER_US = CLK_PER_US_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic tick
);
    localparam int PW = $clog2(CLK_PER_US + 1);

    logic [PW-1:0] cnt;

    assign tick = cnt == PW'(CLK_PER_US - 1);

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt <= '0;
        else          cnt <= (clr || tick) ? '0 : cnt + 1'b1;

endmodule

// File: rtl/pulse_sched.sv
// pulse_sched: schedules DDS pulse windows of T us repeating every Z*T us (optional guard: PULSE_SCHED_GUARD_EN)
//   clk, reset_n        : clock, async active-low reset
//   run                 : level enable for scheduling
//   cfg_valid, T, Z     : config strobe, pulse width (us), duty divisor
//   dds_en              : high during the pulse window
//   chirp_start         : one-cycle pulse on the first cycle of each window
//   cfg_ack             : one-cycle pulse in the cycle pending config is applied
//   pulse_cnt           : wrapping count of issued pulses
//   state_o             : 0 IDLE, 1 ON, 2 OFF, 3 GUARD
module pulse_sched
    import radar_pkg::*;
#(
    parameter int CLK_PER_US = CLK_PER_US_DEF,
    parameter int GUARD_US   = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic              cfg_valid,
    input  logic [T_W-1:0]    T,
    input  logic [Z_W-1:0]    Z,
    output logic              dds_en,
    output logic              chirp_start,
    output logic              cfg_ack,
    output logic [PCNT_W-1:0] pulse_cnt,
    output logic [1:0]        state_o
);
    state_t          state, nxt;
    logic [T_W-1:0]  t_a, t_p, new_t, nt, us_cnt;
    logic [Z_W-1:0]  z_a, z_p, new_z, nz, seg_cnt;
    logic            pend, tick, seg_end, off_end, period_end, apply, nvalid, start;

    us_tick_gen #(.CLK_PER_US(CLK_PER_US)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (start),
        .tick    (tick)
    );

    // a segment is T_a microseconds; OFF is Z_a-1 such segments
    assign seg_end = tick && us_cnt == t_a - 1'b1;
    assign off_end = seg_end && seg_cnt == z_a - Z_W'(2);

`ifdef PULSE_SCHED_GUARD_EN
    localparam int     GW       = $clog2(GUARD_US + 1);
    localparam state_t AFTER_ON = S_GUARD;

    logic [GW-1:0] g_cnt;
    logic          g_end, off_done;

    // OFF time keeps running underneath GUARD; off_done remembers it expired first
    assign g_end      = state == S_GUARD && tick && g_cnt == GW'(GUARD_US - 1);
    assign period_end = (state == S_OFF && off_end) ||
                        (g_end && (off_done || off_end || z_a == Z_W'(1)));

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            g_cnt    <= '0;
            off_done <= 1'b0;
        end else begin
            g_cnt    <= (state == S_GUARD) ? g_cnt + GW'(tick) : '0;
            off_done <= state == S_GUARD && (off_done || off_end);
        end
`else
    localparam state_t AFTER_ON = S_OFF;

    assign period_end = (state == S_ON && seg_end && z_a == Z_W'(1)) || (state == S_OFF && off_end);
`endif

    // a strobe in the apply cycle itself wins over the older pending pair
    assign apply  = reset_n && (pend || cfg_valid) && (state == S_IDLE || period_end);
    assign new_t  = cfg_valid ? T : t_p;
    assign new_z  = cfg_valid ? Z : z_p;
    assign nt     = apply ? new_t : t_a;
    assign nz     = apply ? new_z : z_a;
    assign nvalid = |nt && |nz;
    assign start  = nxt == S_ON && (state != S_ON || period_end);

    always_comb begin
        nxt = state;
        if (!run)                                 nxt = S_IDLE;
        else if (state == S_IDLE || period_end)   nxt = nvalid ? S_ON : S_IDLE;
        else if (state == S_ON && seg_end)        nxt = AFTER_ON;
`ifdef PULSE_SCHED_GUARD_EN
        else if (g_end)                           nxt = S_OFF;
`endif
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state       <= S_IDLE;
            chirp_start <= 1'b0;
            pulse_cnt   <= '0;
            pend        <= 1'b0;
            t_a         <= '0;
            z_a         <= '0;
            t_p         <= '0;
            z_p         <= '0;
            us_cnt      <= '0;
            seg_cnt     <= '0;
        end else begin
            state       <= nxt;
            chirp_start <= start;
            pulse_cnt   <= pulse_cnt + PCNT_W'(start);
            pend        <= !apply && (pend || cfg_valid);
            if (apply) begin
                t_a <= new_t;
                z_a <= new_z;
            end
            if (cfg_valid) begin
                t_p <= T;
                z_p <= Z;
            end
            us_cnt      <= (start || nxt == S_IDLE || seg_end) ? '0 : us_cnt + T_W'(tick);
            seg_cnt     <= (start || nxt == S_IDLE || state == S_ON) ? '0 : seg_cnt + Z_W'(seg_end);
        end

    assign dds_en  = state == S_ON;
    assign cfg_ack = apply;
    assign state_o = state;

endmodule

// File: tb/tb_pulse_sched.sv
// tb_pulse_sched: scoreboard bench for pulse_sched with CLK_PER_US=4
module tb_pulse_sched;
    import radar_pkg::*;

    logic        clk = 1'b0, reset_n = 1'b1, run = 1'b0, cfg_valid = 1'b0;
    logic [10:0] T = '0;
    logic [6:0]  Z = '0;
    logic        dds_en, chirp_start, cfg_ack;
    logic [15:0] pulse_cnt;
    logic [1:0]  state_o;
    int          cyc = 0, n_cmp = 0, n_bad = 0;

    typedef struct {
        int          cyc;
        logic [1:0]  st;
        logic        dds;
        logic        chirp;
        logic        ack;
        logic [15:0] pc;
    } ev_t;

    ev_t exp_q[$];

    pulse_sched #(.CLK_PER_US(4), .GUARD_US(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .cfg_valid   (cfg_valid),
        .T           (T),
        .Z           (Z),
        .dds_en      (dds_en),
        .chirp_start (chirp_start),
        .cfg_ack     (cfg_ack),
        .pulse_cnt   (pulse_cnt),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic ev(int c, logic [1:0] st, logic ch, logic ak, logic [15:0] pc);
        exp_q.push_back('{c, st, st == 2'd1, ch, ak, pc});
    endtask

    task automatic at(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg(int t, int z);
        cfg_valid = 1'b1;
        T = 11'(t);
        Z = 7'(z);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic chk(string n, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", n, got, want);
        end
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_dds_en"}, int'(dds_en), 0);
        chk({tag, "_chirp"}, int'(chirp_start), 0);
        chk({tag, "_ack"}, int'(cfg_ack), 0);
        chk({tag, "_pulse_cnt"}, int'(pulse_cnt), 0);
        chk({tag, "_state"}, int'(state_o), 0);
    endtask

    // monitor: every chirp, ack or state change is an output event matched against the queue
    initial begin
        logic [1:0] prev;
        ev_t        e;
        prev = 2'd0;
        forever begin
            @(negedge clk);
            if (!reset_n) prev = 2'd0;
            else if (chirp_start || cfg_ack || state_o != prev) begin
                prev = state_o;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event cyc=%0d st=%0d chirp=%0b ack=%0b pc=%0d",
                             cyc, state_o, chirp_start, cfg_ack, pulse_cnt);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.st != state_o || e.dds != dds_en || e.chirp != chirp_start ||
                        e.ack != cfg_ack || e.pc != pulse_cnt) begin
                        n_bad++;
                        $display("FAIL event got cyc=%0d st=%0d dds=%0b chirp=%0b ack=%0b pc=%0d want cyc=%0d st=%0d dds=%0b chirp=%0b ack=%0b pc=%0d",
                                 cyc, state_o, dds_en, chirp_start, cfg_ack, pulse_cnt,
                                 e.cyc, e.st, e.dds, e.chirp, e.ack, e.pc);
                    end
                end
            end
        end
    end

    initial begin
        // T=3 Z=4: ack, ON 12, OFF 36, period 48
        ev(10, 0, 0, 1, 0);
        ev(11, 1, 1, 0, 1);
        ev(23, 2, 0, 0, 1);
        ev(59, 1, 1, 0, 2);
        // run dropped mid-ON, then re-asserted
        ev(63, 0, 0, 0, 2);
        ev(66, 1, 1, 0, 3);
        ev(78, 2, 0, 0, 3);
        ev(114, 1, 1, 0, 4);
        // T=2 Z=2 queued during ON, applied on last OFF cycle
        ev(126, 2, 0, 0, 4);
        ev(161, 2, 0, 1, 4);
        ev(162, 1, 1, 0, 5);
        ev(170, 2, 0, 0, 5);
        ev(178, 1, 1, 0, 6);
        ev(186, 2, 0, 0, 6);
        ev(194, 1, 1, 0, 7);
        // T=5 Z=1: continuous ON, chirp every 20
        ev(202, 2, 0, 0, 7);
        ev(209, 2, 0, 1, 7);
        ev(210, 1, 1, 0, 8);
        ev(230, 1, 1, 0, 9);
        ev(250, 1, 1, 0, 10);
        ev(270, 1, 1, 0, 11);
        // Z=0 applied at period end -> IDLE; Z=0 in IDLE -> ack only
        ev(289, 1, 0, 1, 11);
        ev(290, 0, 0, 0, 11);
        ev(295, 0, 0, 1, 11);
        ev(300, 0, 0, 1, 11);
        ev(301, 1, 1, 0, 12);
        // after reset: T=3 Z=2
        ev(330, 0, 0, 1, 0);
        ev(331, 1, 1, 0, 1);
`ifdef PULSE_SCHED_GUARD_EN
        ev(343, 3, 0, 0, 1);
        ev(351, 2, 0, 0, 1);
        ev(355, 1, 1, 0, 2);
        ev(367, 3, 0, 0, 2);
`else
        ev(343, 2, 0, 0, 1);
        ev(355, 1, 1, 0, 2);
        ev(367, 2, 0, 0, 2);
`endif

        #1 reset_n = 1'b0;
        at(3);
        chk_zero("reset");
        at(5);
        reset_n = 1'b1;
        at(6);
        run = 1'b1;
        at(10);
        cfg(3, 4);
        at(62);
        run = 1'b0;
        at(65);
        run = 1'b1;
        at(116);
        cfg(2, 2);
        at(196);
        cfg(5, 1);
        at(272);
        cfg(3, 0);
        at(295);
        cfg(4, 0);
        at(300);
        cfg(3, 4);
        at(305);
        reset_n = 1'b0;
        #1;
        chk_zero("async_reset");
        at(307);
        reset_n = 1'b1;
        at(330);
        cfg(3, 2);
        at(370);
        chk("leftover_events", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
